// File: rtl/bcd_disp_pkg.sv
// Shared types and constant helpers for the BCD digit scanner.
package bcd_disp_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    // Largest value representable on n decimal digits.
    function automatic logic [63:0] pow10_minus1(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    function automatic int unsigned scan_cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_scanner_bin2bcd_dd.sv
// Sequential double-dabble engine: one add-3/shift iteration per clock.
module bin2bcd_dd
    import bcd_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    done
);

    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned ITER_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]  sh_bin;
    logic [ITER_W-1:0] iter;
    logic [BCD_W-1:0]  adj;

    always_comb begin
        adj = bcd;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // High during the final iteration so the parent can leave CONV on the same edge.
    assign done = (iter == ITER_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_bin <= '0;
            bcd    <= '0;
            iter   <= '0;
        end else if (start) begin
            sh_bin <= bin_in;
            bcd    <= '0;
            iter   <= ITER_W'(BIN_W);
        end else if (iter != '0) begin
            bcd    <= {adj[BCD_W-2:0], sh_bin[BIN_W-1]};
            sh_bin <= sh_bin << 1;
            iter   <= iter - ITER_W'(1);
        end
    end

endmodule

// File: rtl/bcd_digit_scanner.sv
// Binary-to-BCD converter and digit multiplexer feeding the seven-segment decoder.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits at commit.
module bcd_digit_scanner
    import bcd_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [3:0]            digit_bcd,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned SCAN_W = scan_cnt_width(SCAN_DIV);
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [63:0] LIMIT  = pow10_minus1(NUM_DIGITS);

    state_t            state;
    logic [BIN_W-1:0]  cap_val;
    logic [BCD_W-1:0]  digits;
    logic [BCD_W-1:0]  dd_bcd;
    logic [BCD_W-1:0]  commit_digits;
    logic              dd_start;
    logic              dd_done;
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  scan_idx_d;

    assign dd_start = (state == IDLE) && load;

    bin2bcd_dd #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_W      (BIN_W)
    ) u_dd (
        .clk    (clk),
        .reset  (reset),
        .start  (dd_start),
        .bin_in (bin_in),
        .bcd    (dd_bcd),
        .done   (dd_done)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic lead;

    always_comb begin
        commit_digits = dd_bcd;
        lead          = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && (dd_bcd[i*4 +: 4] == 4'd0)) begin
                commit_digits[i*4 +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    always_comb begin
        commit_digits = dd_bcd;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
            digits   <= {NUM_DIGITS{BCD_BLANK}};
            cap_val  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        cap_val <= bin_in;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    if (dd_done) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    // Range check uses the captured binary value, not BCD carry-out.
                    if (64'(cap_val) > LIMIT) begin
                        overflow <= 1'b1;
                        digits   <= {NUM_DIGITS{BCD_BLANK}};
                    end else begin
                        overflow <= 1'b0;
                        digits   <= commit_digits;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // an trails digit_bcd by one cycle to match the decoder's output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt   <= '0;
            scan_idx   <= '0;
            scan_idx_d <= '0;
            digit_bcd  <= BCD_BLANK;
            an         <= '1;
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            digit_bcd  <= digits[scan_idx*4 +: 4];
            scan_idx_d <= scan_idx;
            an         <= ~(NUM_DIGITS'(1) << scan_idx_d);
        end
    end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Scoreboard bench for bcd_digit_scanner with a short scan period.
module tb_bcd_digit_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] bin_in = '0;
    logic        load = 1'b0;
    logic        busy;
    logic        overflow;
    logic [3:0]  digit_bcd;
    logic [3:0]  an;

    typedef struct {
        logic [15:0] digs;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    bcd_digit_scanner #(
        .NUM_DIGITS (4),
        .BIN_W      (14),
        .SCAN_DIV   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bin_in    (bin_in),
        .load      (load),
        .busy      (busy),
        .overflow  (overflow),
        .digit_bcd (digit_bcd),
        .an        (an)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] model(input int unsigned v);
        logic [15:0] d;
`ifdef LEADING_ZERO_BLANK_EN
        bit lead;
`endif
        if (v > 9999) return 16'hFFFF;
        for (int unsigned i = 0; i < 4; i++) d[i*4 +: 4] = 4'((v / (10 ** i)) % 10);
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && d[i*4 +: 4] == 4'd0) d[i*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return d;
    endfunction

    task automatic do_load(input logic [13:0] v, input bit accept);
        @(negedge clk);
        bin_in = v;
        load   = 1'b1;
        if (accept) sb.push_back('{model(v), (v > 14'd9999)});
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("conv_done", busy, 0);
    endtask

    task automatic scan_check(input string tag);
        exp_t       e;
        logic [3:0] prev;
        logic [3:0] en_exp;
        int         k_wait;
        if (sb.size() == 0) begin
            check({tag, "_sb"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_ovf"}, overflow, e.ovf);
        repeat (4) @(negedge clk);
        prev   = an;
        k_wait = 0;
        @(negedge clk);
        while (!(an == 4'b1110 && prev != 4'b1110) && k_wait < 40) begin
            prev = an;
            @(negedge clk);
            k_wait++;
        end
        check({tag, "_sync"}, an, 4'b1110);
        for (int unsigned k = 0; k < 4; k++) begin
            en_exp = ~(4'(1) << k);
            check($sformatf("%s_d%0d", tag, k), digit_bcd, e.digs[k*4 +: 4]);
            check($sformatf("%s_an%0d", tag, k), an, en_exp);
            repeat (3) @(negedge clk);
            if (k < 3) begin
                check($sformatf("%s_lag%0d", tag, k), {an, digit_bcd},
                      {en_exp, e.digs[(k+1)*4 +: 4]});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_digit", digit_bcd, 4'hF);
        check("rst_an", an, 4'hF);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_an", an, 4'b1110);
        check("rel_digit", digit_bcd, 4'hF);
        sb.push_back('{16'hFFFF, 1'b0});
        scan_check("rel_scan");

        do_load(14'd1234, 1'b1);
        wait_idle(n);
        check("busy_len", n, 15);
        scan_check("v1234");

        do_load(14'd10000, 1'b1);
        wait_idle(n);
        check("busy_len_ovf", n, 15);
        scan_check("v10000");

        do_load(14'd9999, 1'b1);
        wait_idle(n);
        scan_check("v9999");

        do_load(14'd42, 1'b1);
        repeat (3) @(negedge clk);
        do_load(14'd7, 1'b0);
        wait_idle(n);
        check("busy_rem", n, 10);
        scan_check("v42");

        do_load(14'd7, 1'b1);
        wait_idle(n);
        scan_check("v7");

        do_load(14'd0, 1'b1);
        wait_idle(n);
        scan_check("v0");

        do_load(14'd16383, 1'b1);
        wait_idle(n);
        scan_check("vmax");

        do_load(14'd5678, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_ovf", overflow, 0);
        check("mid_digit", digit_bcd, 4'hF);
        check("mid_an", an, 4'hF);
        @(negedge clk);
        reset = 1'b1;
        sb.push_back('{16'hFFFF, 1'b0});
        repeat (20) @(negedge clk);
        check("mid_idle", busy, 0);
        scan_check("mid_scan");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
